// File: rtl/word_assembler_pkg.sv
// Shared types, default sizes and lane-ordering helper for the byte-to-word assembler.
package word_assembler_pkg;

    localparam int BYTE_W_DEF = 8;
    localparam int LANES_DEF  = 2;
    localparam int N_CH_DEF   = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2
    } acc_state_t;

    // Lane written by the k-th byte of a word.
    function automatic int lane_index(input int k, input logic big_endian, input int lanes);
        return big_endian ? (lanes - 1 - k) : k;
    endfunction

endpackage

// File: rtl/word_assembler_if.sv
// Byte-in / word-out handshake bundle for word_assembler.
interface word_assembler_if
    import word_assembler_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int N_CH   = N_CH_DEF
) ();
    localparam int WORD_W = LANES * BYTE_W;
    localparam int CH_W   = $clog2(N_CH);
    localparam int CNT_W  = $clog2(LANES + 1);

    logic [N_CH*BYTE_W-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [CH_W-1:0]        sel;
    logic                   big_endian;
    logic                   flush;
    logic [WORD_W-1:0]      out_word;
    logic [CNT_W-1:0]       out_count;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;

    modport master (
        output in_data, in_valid, sel, big_endian, flush, out_ready,
        input  in_ready, out_word, out_count, out_valid, busy
    );

    modport slave (
        input  in_data, in_valid, sel, big_endian, flush, out_ready,
        output in_ready, out_word, out_count, out_valid, busy
    );

endinterface

// File: rtl/word_assembler_byte_channel_mux.sv
// N_CH:1 byte selector; an out-of-range select yields an all-zero byte.
module byte_channel_mux
    import word_assembler_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int N_CH   = N_CH_DEF,
    parameter int CH_W   = $clog2(N_CH)
) (
    input  logic [N_CH*BYTE_W-1:0] data,
    input  logic [CH_W-1:0]        sel,
    output logic [BYTE_W-1:0]      byte_out
);

    always_comb begin
        byte_out = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (int'(sel) == c) byte_out = data[c*BYTE_W +: BYTE_W];
        end
    end

endmodule

// File: rtl/word_assembler.sv
// Gathers LANES bytes from a selected channel into one word, with flush, endianness
// and a decoupled output register so the next word can fill behind a stalled one.
module word_assembler
    import word_assembler_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int N_CH   = N_CH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    word_assembler_if.slave  bus
);
    localparam int WORD_W = LANES * BYTE_W;
    localparam int CH_W   = $clog2(N_CH);
    localparam int CNT_W  = $clog2(LANES + 1);

    acc_state_t                   state, state_nxt;
    logic [LANES-1:0][BYTE_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]             cnt, cnt_nxt;
    logic [CH_W-1:0]              cap_sel, eff_sel;
    logic                         cap_be, eff_be;
    logic [BYTE_W-1:0]            mux_byte;
    logic                         in_ready, accept, last_byte, slot_free;
    logic                         load_out, clear_acc;
    int                           lane;

    logic [WORD_W-1:0]            out_word_q;
    logic [CNT_W-1:0]             out_count_q;
    logic                         out_valid_q;

    assign in_ready  = (state != STALL);
    assign accept    = bus.in_valid && in_ready;
    assign last_byte = accept && (int'(cnt) == LANES - 1);
    assign slot_free = !out_valid_q || bus.out_ready;

    // Byte 0 takes sel/endian live; later bytes use what was captured with byte 0.
    assign eff_sel = (state == EMPTY) ? bus.sel        : cap_sel;
    assign eff_be  = (state == EMPTY) ? bus.big_endian : cap_be;

    byte_channel_mux #(
        .BYTE_W (BYTE_W),
        .N_CH   (N_CH),
        .CH_W   (CH_W)
    ) u_mux (
        .data     (bus.in_data),
        .sel      (eff_sel),
        .byte_out (mux_byte)
    );

    assign lane    = lane_index(int'(cnt), eff_be, LANES);
    assign cnt_nxt = cnt + CNT_W'(accept);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign acc_nxt[l] = (accept && lane == l) ? mux_byte : acc[l];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        clear_acc = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) state_nxt = FILL;
            end
            FILL: begin
                if (last_byte || bus.flush) begin
                    if (slot_free) begin
                        load_out  = 1'b1;
                        clear_acc = 1'b1;
                        state_nxt = EMPTY;
                    end else begin
                        state_nxt = STALL;
                    end
                end
            end
            STALL: begin
                // Completed word parked in acc; acc_nxt/cnt_nxt equal acc/cnt here.
                if (slot_free) begin
                    load_out  = 1'b1;
                    clear_acc = 1'b1;
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            cap_sel <= '0;
            cap_be  <= 1'b0;
        end else begin
            if (clear_acc) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt_nxt;
            end
            if (accept && state == EMPTY) begin
                cap_sel <= bus.sel;
                cap_be  <= bus.big_endian;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else if (load_out) begin
            out_word_q  <= acc_nxt;
            out_count_q <= cnt_nxt;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_word  = out_word_q;
    assign bus.out_count = out_count_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state != EMPTY);

endmodule

// File: tb/tb_word_assembler.sv
// Directed and random checks of word_assembler against a byte/word queue model.
module tb_word_assembler;
    import word_assembler_pkg::*;

    localparam int BW  = 8;
    localparam int LN  = 2;
    localparam int NC  = 3;
    localparam int LN4 = 4;
    localparam int NC4 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    word_assembler_if #(.BYTE_W(BW), .LANES(LN),  .N_CH(NC))  bus  ();
    word_assembler_if #(.BYTE_W(BW), .LANES(LN4), .N_CH(NC4)) bus4 ();

    word_assembler #(.BYTE_W(BW), .LANES(LN),  .N_CH(NC))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    word_assembler #(.BYTE_W(BW), .LANES(LN4), .N_CH(NC4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: bytes of the word being gathered, plus completed words not yet consumed.
    typedef struct {
        logic [15:0] w;
        int          c;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  pb[$];
    int          psel;
    bit          pbe;

    function automatic void model_clear();
        q.delete();
        pb.delete();
    endfunction

    function automatic void model_step();
        bit         acc, cons, was_fill;
        logic [7:0] b;
        exp_t       e;
        acc      = bus.in_valid && (q.size() < 2);
        cons     = (q.size() > 0) && bus.out_ready;
        was_fill = (pb.size() > 0);
        if (acc) begin
            if (!was_fill) begin
                psel = int'(bus.sel);
                pbe  = bus.big_endian;
            end
            b = (psel < NC) ? bus.in_data[psel*BW +: BW] : 8'h00;
            pb.push_back(b);
        end
        if (cons) void'(q.pop_front());
        if (pb.size() == LN || (bus.flush && was_fill)) begin
            e.w = '0;
            e.c = pb.size();
            for (int k = 0; k < pb.size(); k++)
                e.w |= 16'(pb[k]) << ((pbe ? LN - 1 - k : k) * BW);
            q.push_back(e);
            pb.delete();
        end
    endfunction

    task automatic check_outs();
        chk("in_ready",  bus.in_ready,  q.size() < 2);
        chk("out_valid", bus.out_valid, q.size() > 0);
        chk("busy",      bus.busy,      pb.size() > 0 || q.size() == 2);
        if (q.size() > 0) begin
            chk("out_word",  bus.out_word,  q[0].w);
            chk("out_count", bus.out_count, q[0].c);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_clear();
        @(negedge clk);
        check_outs();
    endtask

    task automatic put(input bit v, input logic [23:0] d, input logic [1:0] s,
                       input bit be, input bit fl, input bit ordy);
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.sel        = s;
        bus.big_endian = be;
        bus.flush      = fl;
        bus.out_ready  = ordy;
        cycle();
    endtask

    task automatic put4(input bit v, input logic [7:0] b, input bit be, input bit fl);
        bus4.in_valid   = v;
        bus4.in_data    = {8'h00, b};
        bus4.sel        = 1'b0;
        bus4.big_endian = be;
        bus4.flush      = fl;
        bus4.out_ready  = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid = 0;  bus.in_data = '0;  bus.sel = '0;  bus.big_endian = 0;
        bus.flush = 0;     bus.out_ready = 0;
        bus4.in_valid = 0; bus4.in_data = '0; bus4.sel = '0; bus4.big_endian = 0;
        bus4.flush = 0;    bus4.out_ready = 1;

        repeat (2) @(negedge clk);
        chk("rst_word",  bus.out_word,  0);
        chk("rst_count", bus.out_count, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy",  bus.busy,      0);
        chk("rst_ready", bus.in_ready,  1);
        rst_n = 1'b1;

        // little-endian, channel 1
        put(1, 24'h003400, 1, 0, 0, 1);
        chk("t1_early", bus.out_valid, 0);
        put(1, 24'h001200, 1, 0, 0, 1);
        chk("t1_word",  bus.out_word,  16'h1234);
        chk("t1_count", bus.out_count, 2);
        chk("t1_valid", bus.out_valid, 1);

        // big-endian; sel/endian changed on byte 1 must not matter
        put(1, 24'h003400, 1, 1, 0, 1);
        put(1, 24'h001299, 0, 0, 0, 1);
        chk("t2_word", bus.out_word, 16'h3412);

        // backpressure: second word parks in the accumulator
        put(0, 24'h0, 1, 0, 0, 1);
        put(1, 24'h00AA00, 1, 0, 0, 0);
        put(1, 24'h00BB00, 1, 0, 0, 0);
        put(1, 24'h00CC00, 1, 0, 0, 0);
        put(1, 24'h00DD00, 1, 0, 0, 0);
        chk("t3_word",  bus.out_word, 16'hBBAA);
        chk("t3_stall", bus.in_ready, 0);
        put(1, 24'h00EE00, 1, 0, 0, 0);
        chk("t3_hold",  bus.out_word, 16'hBBAA);
        put(0, 24'h0, 1, 0, 0, 1);
        chk("t3_next",  bus.out_word, 16'hDDCC);
        put(0, 24'h0, 1, 0, 0, 1);
        chk("t3_drain", bus.out_valid, 0);

        // flush of a partial word, then flush while idle
        put(1, 24'h005A00, 1, 0, 0, 1);
        put(0, 24'h0, 1, 0, 1, 1);
        chk("t4_word",  bus.out_word,  16'h005A);
        chk("t4_count", bus.out_count, 1);
        put(0, 24'h0, 1, 0, 1, 1);
        put(0, 24'h0, 1, 0, 1, 1);
        chk("t4_idle",  bus.out_valid, 0);
        chk("t4_busy",  bus.busy,      0);

        // out-of-range channel reads zero
        put(1, 24'hFFFFFF, 3, 0, 0, 1);
        put(1, 24'hFFFFFF, 0, 0, 0, 1);
        chk("t5_word", bus.out_word, 16'h0000);

        // async reset with a pending word and a partial one
        put(1, 24'h005500, 1, 0, 0, 0);
        put(1, 24'h006600, 1, 0, 0, 0);
        put(1, 24'h007700, 1, 0, 0, 0);
        chk("t6_pre", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_word",  bus.out_word,  0);
        chk("t6_count", bus.out_count, 0);
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_busy",  bus.busy,      0);
        model_clear();
        put(0, 24'h0, 0, 0, 0, 1);
        put(0, 24'h0, 0, 0, 0, 1);
        rst_n = 1'b1;
        put(1, 24'h007700, 1, 0, 0, 1);
        put(1, 24'h006600, 1, 0, 0, 1);
        chk("t6_after", bus.out_word, 16'h6677);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            put(($urandom % 10) < 7, 24'($urandom), 2'($urandom_range(0, 3)),
                1'($urandom % 2), ($urandom % 8) == 0, ($urandom % 10) < 6);
        end
        bus.in_valid = 0;
        bus.flush    = 0;

        // four-lane instance
        put4(1, 8'h01, 0, 0); put4(1, 8'h02, 0, 0); put4(1, 8'h03, 0, 0); put4(1, 8'h04, 0, 0);
        chk("l4_le",    bus4.out_word,  32'h04030201);
        chk("l4_count", bus4.out_count, 4);
        put4(1, 8'h01, 1, 0); put4(1, 8'h02, 1, 0); put4(1, 8'h03, 1, 0); put4(1, 8'h04, 1, 0);
        chk("l4_be",    bus4.out_word,  32'h01020304);
        put4(1, 8'h11, 0, 0); put4(1, 8'h22, 0, 1);
        chk("l4_flush", bus4.out_word,  32'h00002211);
        chk("l4_fcnt",  bus4.out_count, 2);
        put4(0, 8'h00, 0, 0);
        chk("l4_idle",  bus4.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
